// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frames bytes from the PS/2 pins and decodes E0/F0 prefixes into key events.
// Optional build macro PS2_RX_PARITY_CHECK_EN drops frames whose odd parity is wrong.
module ps2_kbd_rx #(
    parameter int unsigned TIMEOUT = 2000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_rel,
    output logic       key_strobe,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    function automatic logic parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

    logic [1:0]  clk_sync_q;
    logic        clk_prev_q;
    logic [1:0]  data_sync_q;
    logic        fall_s;
    logic        bit_s;
    logic        good_s;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [15:0] tmo_q, tmo_d;
    logic        ext_q, ext_d;
    logic        rel_q, rel_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  key_code_q, key_code_d;
    logic        key_ext_q, key_ext_d;
    logic        key_rel_q, key_rel_d;
    logic        key_strobe_q, key_strobe_d;
    logic        frame_err_q, frame_err_d;

    // Pin synchronizers reset to the idle-high line level so reset never fakes a falling edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            clk_prev_q  <= 1'b1;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            clk_prev_q  <= clk_sync_q[1];
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end

    assign fall_s = clk_prev_q & ~clk_sync_q[1];
    assign bit_s  = data_sync_q[1];

`ifdef PS2_RX_PARITY_CHECK_EN
    assign good_s = bit_s & parity_ok(shift_q, par_q);
`else
    assign good_s = bit_s;
`endif

    // Next-state logic: decoder first, then frame receive / timeout (timeout may override prefix flags).
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        tmo_d        = tmo_q;
        ext_d        = ext_q;
        rel_d        = rel_q;
        rx_byte_d    = rx_byte_q;
        rx_valid_d   = 1'b0;
        key_code_d   = key_code_q;
        key_ext_d    = key_ext_q;
        key_rel_d    = key_rel_q;
        key_strobe_d = 1'b0;
        frame_err_d  = 1'b0;

        if (rx_valid_q) begin
            if (rx_byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (rx_byte_q == 8'hF0) begin
                rel_d = 1'b1;
            end else begin
                key_code_d   = rx_byte_q;
                key_ext_d    = ext_q;
                key_rel_d    = rel_q;
                key_strobe_d = 1'b1;
                ext_d        = 1'b0;
                rel_d        = 1'b0;
            end
        end else begin
            key_strobe_d = 1'b0;
        end

        if (fall_s) begin
            tmo_d = 16'd0;
            case (state_q)
                S_IDLE: begin
                    if (!bit_s) begin
                        state_d = S_DATA;
                        cnt_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DATA: begin
                    shift_d[cnt_q] = bit_s;
                    if (cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                S_PARITY: begin
                    par_d   = bit_s;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    if (good_s) begin
                        rx_byte_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else if (state_q == S_IDLE) begin
            tmo_d = 16'd0;
        end else if (tmo_q == TMO_LAST) begin
            state_d     = S_IDLE;
            tmo_d       = 16'd0;
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            rel_d       = 1'b0;
        end else begin
            tmo_d = tmo_q + 16'd1;
        end
    end

    // Receive FSM, decoder state and registered outputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            shift_q      <= 8'd0;
            par_q        <= 1'b0;
            tmo_q        <= 16'd0;
            ext_q        <= 1'b0;
            rel_q        <= 1'b0;
            rx_byte_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            key_code_q   <= 8'd0;
            key_ext_q    <= 1'b0;
            key_rel_q    <= 1'b0;
            key_strobe_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            ext_q        <= ext_d;
            rel_q        <= rel_d;
            rx_byte_q    <= rx_byte_d;
            rx_valid_q   <= rx_valid_d;
            key_code_q   <= key_code_d;
            key_ext_q    <= key_ext_d;
            key_rel_q    <= key_rel_d;
            key_strobe_q <= key_strobe_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_byte    = rx_byte_q;
    assign rx_valid   = rx_valid_q;
    assign key_code   = key_code_q;
    assign key_ext    = key_ext_q;
    assign key_rel    = key_rel_q;
    assign key_strobe = key_strobe_q;
    assign frame_err  = frame_err_q;

endmodule
